// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts in IF, trains and redirects from EX, and counts branches and mispredictions.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [31:0]      ex_pc,
    input  logic [3:0]       ex_branch,
    input  logic             ex_meet,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                is_br, act, upd;
    logic [31:0]         if_seq, ex_seq;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[31:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[31:IDX_BITS+2];
    assign if_seq = if_pc + 32'd4;
    assign ex_seq = ex_pc + 32'd4;

    // rst gating keeps the prediction clean before the first reset edge clears valid
    assign if_hit      = !rst && valid[if_idx] && (tag[if_idx] == if_tag);
    assign ex_hit      = valid[ex_idx] && (tag[ex_idx] == ex_tag);
    assign pred_taken  = if_hit && ctr[if_idx][1];
    assign pred_target = pred_taken ? target[if_idx] : if_seq;

    always_comb begin
        is_br = 1'b0;
        case (ex_branch)
            4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1011: is_br = 1'b1;
            default: is_br = 1'b0;
        endcase
    end

    assign act = ex_valid && !ex_stall;
    assign upd = act && !rst;

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (act) begin
            if (is_br)
                mispredict = (ex_pred_taken != ex_meet) ||
                             (ex_pred_taken && ex_meet && (ex_pred_target != ex_target));
            else
                mispredict = ex_pred_taken;
            if (mispredict)
                redirect_pc = (is_br && ex_meet) ? ex_target : ex_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            br_count <= '0;
            mp_count <= '0;
        end else if (upd) begin
            if (is_br) begin
                if (ex_hit) begin
                    if (ex_meet) begin
                        if (ctr[ex_idx] != 2'b11)
                            ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                        target[ex_idx] <= ex_target;
                    end else if (ctr[ex_idx] != 2'b00) begin
                        ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
                    end
                end else if (ex_meet) begin
                    valid[ex_idx]  <= 1'b1;
                    tag[ex_idx]    <= ex_tag;
                    target[ex_idx] <= ex_target;
                    ctr[ex_idx]    <= 2'b10;
                end
                if (br_count != '1)
                    br_count <= br_count + CNT_W'(1);
            end else if (ex_pred_taken && ex_hit) begin
                // a taken prediction on a non-branch means the entry is an alias
                valid[ex_idx] <= 1'b0;
            end
            if (mispredict && (mp_count != '1))
                mp_count <= mp_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: per-cycle stimulus with hand-computed outputs.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_stall;
    logic [31:0] ex_pc;
    logic [3:0]  ex_branch;
    logic        ex_meet;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count, mp_count;

    int tests  = 0;
    int failed = 0;

    branch_predictor #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_meet(ex_meet),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        v, s;
        logic [31:0] pc;
        logic [3:0]  br;
        logic        meet;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rpc, e_br, e_mpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] ifp, logic v, logic s, logic [31:0] pc,
                                logic [3:0] br, logic meet, logic [31:0] tgt, logic ptk,
                                logic [31:0] ptgt, logic e_pt, logic [31:0] e_ptgt,
                                logic e_mp, logic [31:0] e_rpc, logic [31:0] e_br,
                                logic [31:0] e_mpc);
        vec_t r;
        r.if_pc = ifp; r.v = v; r.s = s; r.pc = pc; r.br = br; r.meet = meet;
        r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
        r.e_mp = e_mp; r.e_rpc = e_rpc; r.e_br = e_br; r.e_mpc = e_mpc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        if_pc = t.if_pc; ex_valid = t.v; ex_stall = t.s; ex_pc = t.pc;
        ex_branch = t.br; ex_meet = t.meet; ex_target = t.tgt;
        ex_pred_taken = t.ptk; ex_pred_target = t.ptgt;
    endtask

    task automatic check_vec(input int i, input vec_t t);
        chk($sformatf("v%0d pred_taken", i),  {31'd0, pred_taken}, {31'd0, t.e_pt});
        chk($sformatf("v%0d pred_target", i), pred_target, t.e_ptgt);
        chk($sformatf("v%0d mispredict", i),  {31'd0, mispredict}, {31'd0, t.e_mp});
        chk($sformatf("v%0d redirect_pc", i), redirect_pc, t.e_rpc);
        chk($sformatf("v%0d br_count", i),    br_count, t.e_br);
        chk($sformatf("v%0d mp_count", i),    mp_count, t.e_mpc);
    endtask

    localparam logic [3:0] BEQ = 4'b0001, BNE = 4'b0011, BLEZ = 4'b1011, NOBR = 4'b0000;

    initial begin
        // ifpc v s expc br meet tgt ptk ptgt | e_pt e_ptgt e_mp e_rpc br mp
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      0,32'h104,0,32'h0,0,0));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,1,32'h140,0,32'h104, 0,32'h104,1,32'h140,0,0));
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h140,0,32'h0,1,1));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,0,32'h140,1,32'h140, 1,32'h140,1,32'h104,1,1));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,0,32'h140,0,32'h104, 0,32'h104,0,32'h0,2,2));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,0,32'h140,0,32'h104, 0,32'h104,0,32'h0,3,2));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,0,32'h140,0,32'h104, 0,32'h104,0,32'h0,4,2));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,1,32'h140,0,32'h104, 0,32'h104,1,32'h140,5,2));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,1,32'h140,0,32'h104, 0,32'h104,1,32'h140,6,3));
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h140,0,32'h0,7,4));
        vecs.push_back(mk(32'h100,1,0,32'h100,BEQ,1,32'h180,1,32'h140, 1,32'h140,1,32'h180,7,4));
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h180,0,32'h0,8,5));
        vecs.push_back(mk(32'h100,1,1,32'h100,BEQ,1,32'h1c0,0,32'h104, 1,32'h180,0,32'h0,8,5));
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h180,0,32'h0,8,5));
        vecs.push_back(mk(32'h100,1,0,32'h100,NOBR,0,32'h0,1,32'h180,  1,32'h180,1,32'h104,8,5));
        vecs.push_back(mk(32'h100,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      0,32'h104,0,32'h0,8,6));
        vecs.push_back(mk(32'h200,1,0,32'h200,4'b1101,1,32'h300,0,32'h204, 0,32'h204,0,32'h0,8,6));
        vecs.push_back(mk(32'h200,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      0,32'h204,0,32'h0,8,6));
        vecs.push_back(mk(32'h204,1,0,32'h204,BNE,1,32'h400,0,32'h208, 0,32'h208,1,32'h400,8,6));
        vecs.push_back(mk(32'h204,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h400,0,32'h0,9,7));
        vecs.push_back(mk(32'hfffffffc,0,0,32'h0,NOBR,0,32'h0,0,32'h0, 0,32'h0,0,32'h0,9,7));
        vecs.push_back(mk(32'h300,1,0,32'h300,BLEZ,0,32'h500,0,32'h304, 0,32'h304,0,32'h0,9,7));
        vecs.push_back(mk(32'h300,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      0,32'h304,0,32'h0,10,7));
        vecs.push_back(mk(32'h204,0,0,32'h0,NOBR,0,32'h0,0,32'h0,      1,32'h400,0,32'h0,10,7));

        rst = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check_vec(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // reset wins over an allocate issued in the same cycle
        rst = 1'b1;
        if_pc = 32'h204; ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = 32'h500;
        ex_branch = BEQ; ex_meet = 1'b1; ex_target = 32'h600;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h504;
        #2;
        chk("rst pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst pred_target", pred_target, 32'h208);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_valid = 1'b0;
        if_pc = 32'h500;
        #2;
        chk("post-rst alloc pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("post-rst alloc pred_target", pred_target, 32'h504);
        chk("post-rst br_count", br_count, 32'd0);
        chk("post-rst mp_count", mp_count, 32'd0);
        if_pc = 32'h204;
        #2;
        chk("post-rst old entry gone", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- IF stage: predicts taken/target for the fetch PC.
- EX stage: takes the resolved outcome from the branch-condition logic (4-bit Branch code plus the taken/meet bit), trains the table and raises a mispredict redirect.
- Counts resolved branches and mispredictions for performance monitoring.

Parameters:
- IDX_BITS, 6, log2 of entry count (64 entries); index = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- if_pc  input  32  current fetch PC (word aligned).
- pred_taken  output  1  IF prediction: entry hit and counter[1]==1.
- pred_target  output  32  predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  input  1  EX holds a valid instruction.
- ex_stall  input  1  EX frozen this cycle; suppresses all updates.
- ex_pc  input  32  PC of the EX instruction.
- ex_branch  input  4  Branch code (0001 beq, 0011 bne, 0101 bgtz, 0111 bgez, 1001 bltz, 1011 blez, else not a branch).
- ex_meet  input  1  resolved condition, 1 = taken.
- ex_target  input  32  computed branch target.
- ex_pred_taken  input  1  pred_taken carried down the pipe with this instruction.
- ex_pred_target  input  32  pred_target carried down the pipe.
- mispredict  output  1  flush IF/ID and redirect fetch this cycle.
- redirect_pc  output  32  correct next PC when mispredict=1, else 0.
- br_count  output  CNT_W  resolved conditional branches.
- mp_count  output  CNT_W  mispredictions.

Behaviour:
- Entry fields: valid, tag, target[31:0], ctr[1:0]. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst=1 at clk edge): all valid bits cleared, br_count=0, mp_count=0. While reset is asserted, pred_taken=0 and pred_target=if_pc+4 (the table is empty). Reset overrides any update issued the same cycle.
- Prediction is combinational from if_pc. A hit requires valid and a matching tag.
- is_br = (ex_branch is one of the six codes above). A code with bit0=1 that is not listed is not a branch.
- upd = ex_valid && !ex_stall && !rst.
- mispredict is combinational (same cycle as EX) and requires ex_valid && !ex_stall. It is asserted when any of the following holds:
  - is_br && ex_pred_taken != ex_meet; or
  - is_br && ex_pred_taken && ex_meet && ex_pred_target != ex_target; or
  - !is_br && ex_pred_taken (alias hit on a non-branch).
- redirect_pc = (is_br && ex_meet) ? ex_target : ex_pc+4. No delay slot.
- Table update at the clk edge when upd:
  - is_br, hit: ctr saturating +1 if ex_meet, -1 if not (11 stays 11, 00 stays 00); target <= ex_target if ex_meet.
  - is_br, miss, ex_meet=1: allocate valid=1, tag, target=ex_target, ctr=10, replacing any occupant.
  - is_br, miss, ex_meet=0: no change.
  - !is_br && ex_pred_taken && hit: invalidate the entry.
- Hit/miss for the update path is evaluated on ex_pc against the current table contents.
- Read-during-write: if IF and EX address the same index in one cycle, IF sees the old contents. The new value is visible from the next cycle.
- Counters at the clk edge when upd && is_br:
  - br_count += 1.
  - mp_count += 1 when mispredict.
  - Non-branch alias mispredicts increment mp_count only.
  - Both counters saturate at all-ones and do not wrap.
- ex_stall=1 or ex_valid=0: mispredict=0, redirect_pc=0, no state change.
- Arithmetic: pc+4 is 32-bit modulo, so 0xFFFFFFFC+4 = 0x00000000.

Test Plan:
- Reset, then any if_pc -> pred_taken=0, pred_target=if_pc+4, br_count=0, mp_count=0.
- EX beq at ex_pc=0x100, meet=1, target=0x140, pred_taken=0 -> mispredict=1, redirect_pc=0x140. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x140; mp_count=1, br_count=1.
- Same branch resolved not-taken three times (with correctly carried predictions) -> ctr 10→01→00. First resolution mispredicts (redirect_pc=0x104), next two do not. A fourth not-taken keeps ctr=00 with no mispredict.
- Entry predicts 0x140, EX resolves taken to 0x180 -> mispredict=1, redirect_pc=0x180, stored target becomes 0x180.
- ex_pc=0x100 carrying pred_taken=1 on a non-branch (ex_branch=0000) -> mispredict=1, redirect_pc=0x104, entry invalidated, br_count unchanged.
- Simultaneous IF read and EX allocate at index 0 -> IF returns the old (miss) result that cycle. ex_stall=1 during a taken branch -> no mispredict, no table or counter change. rst asserted in the same cycle as an allocate -> table empty afterwards.
